// File: rtl/remote_controller_param.sv
// Serial remote-control frame decoder: start sequence, custom code, key and
// inverted key, with validation, repeat counting and an error pulse.
module remote_controller_param #(
    parameter int unsigned             CUSTOM_BITS  = 16,
    parameter int unsigned             KEY_BITS     = 8,
    parameter int unsigned             CHECK_CUSTOM = 1,
    parameter logic [CUSTOM_BITS-1:0]  CUSTOM_ID    = '0,
    parameter int unsigned             MAX_KEY      = 31,
    parameter int unsigned             READY_CYCLES = 3
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   serial,
    output logic                   ready,
    output logic [KEY_BITS-1:0]    remote_key,
    output logic [CUSTOM_BITS-1:0] custom_code,
    output logic                   frame_error,
    output logic [7:0]             repeat_count
);

    localparam int unsigned CNT_W = 32;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_HIGH,
        CUSTOM,
        KEY,
        INV,
        CHECK,
        VALID
    } state_t;

    state_t                 state, state_d;
    logic [CNT_W-1:0]       cnt, cnt_d;
    logic [CUSTOM_BITS-1:0] custom_sr, custom_sr_d;
    logic [KEY_BITS-1:0]    key_sr, key_sr_d;
    logic [KEY_BITS-1:0]    inv_sr, inv_sr_d;
    logic [KEY_BITS-1:0]    last_key, last_key_d;
    logic                   last_valid, last_valid_d;
    logic                   ready_d;
    logic [KEY_BITS-1:0]    remote_key_d;
    logic [CUSTOM_BITS-1:0] custom_code_d;
    logic                   frame_error_d;
    logic [7:0]             repeat_count_d;
    logic                   frame_ok_c;

    // Frame acceptance: complementary key pair, key in range, custom code match if enabled
    always_comb begin
        frame_ok_c = ((key_sr ^ inv_sr) == {KEY_BITS{1'b1}})
                  && (CNT_W'(key_sr) <= CNT_W'(MAX_KEY))
                  && ((CHECK_CUSTOM == 0) || (custom_sr == CUSTOM_ID));
    end

    // Next-state and next-output logic
    always_comb begin
        state_d        = state;
        cnt_d          = cnt;
        custom_sr_d    = custom_sr;
        key_sr_d       = key_sr;
        inv_sr_d       = inv_sr;
        last_key_d     = last_key;
        last_valid_d   = last_valid;
        ready_d        = ready;
        remote_key_d   = remote_key;
        custom_code_d  = custom_code;
        frame_error_d  = 1'b0;
        repeat_count_d = repeat_count;

        case (state)
            IDLE: begin
                cnt_d       = '0;
                custom_sr_d = '0;
                key_sr_d    = '0;
                inv_sr_d    = '0;
                if (!serial) state_d = WAIT_HIGH;
            end
            WAIT_HIGH: begin
                if (serial) state_d = CUSTOM;
            end
            CUSTOM: begin
                custom_sr_d = {custom_sr[CUSTOM_BITS-2:0], serial};
                if (cnt == CNT_W'(CUSTOM_BITS - 1)) begin
                    cnt_d   = '0;
                    state_d = KEY;
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end
            KEY: begin
                key_sr_d = {key_sr[KEY_BITS-2:0], serial};
                if (cnt == CNT_W'(KEY_BITS - 1)) begin
                    cnt_d   = '0;
                    state_d = INV;
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end
            INV: begin
                inv_sr_d = {inv_sr[KEY_BITS-2:0], serial};
                if (cnt == CNT_W'(KEY_BITS - 1)) begin
                    cnt_d   = '0;
                    state_d = CHECK;
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end
            CHECK: begin
                cnt_d = '0;
                if (frame_ok_c) begin
                    state_d       = VALID;
                    ready_d       = 1'b1;
                    remote_key_d  = key_sr;
                    custom_code_d = custom_sr;
                    if (last_valid && (key_sr == last_key)) begin
                        repeat_count_d = (repeat_count == 8'hFF) ? 8'hFF : repeat_count + 8'd1;
                    end else begin
                        repeat_count_d = 8'd0;
                    end
                    last_key_d   = key_sr;
                    last_valid_d = 1'b1;
                end else begin
                    state_d        = IDLE;
                    frame_error_d  = 1'b1;
                    repeat_count_d = 8'd0;
                    last_valid_d   = 1'b0;
                end
            end
            VALID: begin
                if (cnt == CNT_W'(READY_CYCLES - 1)) begin
                    cnt_d        = '0;
                    state_d      = IDLE;
                    ready_d      = 1'b0;
                    remote_key_d = {KEY_BITS{1'b1}};
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, datapath and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            cnt          <= '0;
            custom_sr    <= '0;
            key_sr       <= '0;
            inv_sr       <= '0;
            last_key     <= '0;
            last_valid   <= 1'b0;
            ready        <= 1'b0;
            remote_key   <= {KEY_BITS{1'b1}};
            custom_code  <= '0;
            frame_error  <= 1'b0;
            repeat_count <= 8'd0;
        end else begin
            state        <= state_d;
            cnt          <= cnt_d;
            custom_sr    <= custom_sr_d;
            key_sr       <= key_sr_d;
            inv_sr       <= inv_sr_d;
            last_key     <= last_key_d;
            last_valid   <= last_valid_d;
            ready        <= ready_d;
            remote_key   <= remote_key_d;
            custom_code  <= custom_code_d;
            frame_error  <= frame_error_d;
            repeat_count <= repeat_count_d;
        end
    end

endmodule

// File: tb/tb_remote_controller_param.sv
// Scoreboard bench: two decoders (custom check on / off) share one serial line.
module tb_remote_controller_param;

    logic        clk = 1'b0;
    logic        reset;
    logic        serial;
    logic        r0, r1, e0, e1;
    logic [7:0]  k0, k1, p0, p1;
    logic [15:0] c0, c1;

    remote_controller_param dut0 (
        .clk(clk), .reset(reset), .serial(serial), .ready(r0), .remote_key(k0),
        .custom_code(c0), .frame_error(e0), .repeat_count(p0)
    );

    remote_controller_param #(.CHECK_CUSTOM(0)) dut1 (
        .clk(clk), .reset(reset), .serial(serial), .ready(r1), .remote_key(k1),
        .custom_code(c1), .frame_error(e1), .repeat_count(p1)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_err;
        logic [7:0]  key;
        logic [15:0] cc;
        logic [7:0]  rep;
        int          cyc;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc   = 0;
    logic rst_q;
    bit   done  = 0;

    // reference model state, one slot per decoder
    bit          m_lv[2];
    logic [7:0]  m_last[2];
    logic [7:0]  m_rep[2];
    logic [15:0] m_cc[2];

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_q <= reset;
    end

    task automatic check(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s dut%0d: got %0h expected %0h (cycle %0d)", nm, idx, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_lv[i] = 0; m_last[i] = 8'h00; m_rep[i] = 8'h00; m_cc[i] = 16'h0000;
        end
    endtask

    // Spec-level decision for one frame; returns the expected observation
    task automatic model_frame(input int idx, input logic [15:0] cust, input logic [7:0] key,
                               input logic [7:0] inv, input int at, output exp_t e);
        bit ok;
        int r;
        ok = ((key ^ inv) == 8'hFF) && (int'(key) <= 31) && ((idx == 1) || (cust == 16'h0000));
        e.cyc = at;
        if (ok) begin
            if (m_lv[idx] && key == m_last[idx]) begin
                r = int'(m_rep[idx]) + 1;
                if (r > 255) r = 255;
            end else begin
                r = 0;
            end
            m_rep[idx]  = 8'(r);
            m_last[idx] = key;
            m_lv[idx]   = 1;
            m_cc[idx]   = cust;
            e.is_err = 0; e.key = key; e.cc = cust; e.rep = 8'(r);
        end else begin
            m_rep[idx] = 8'h00;
            m_lv[idx]  = 0;
            e.is_err = 1; e.key = 8'hFF; e.cc = m_cc[idx]; e.rep = 8'h00;
        end
    endtask

    task automatic send_bit(input logic b);
        serial = b;
        @(negedge clk);
    endtask

    task automatic send_frame(input logic [15:0] cust, input logic [7:0] key, input logic [7:0] inv,
                              input int nlow, input int gap);
        exp_t e;
        for (int i = 0; i < nlow; i++) send_bit(1'b0);
        send_bit(1'b1);
        for (int i = 15; i >= 0; i--) send_bit(cust[i]);
        for (int i = 7; i >= 0; i--) send_bit(key[i]);
        for (int i = 7; i >= 0; i--) send_bit(inv[i]);
        model_frame(0, cust, key, inv, cyc + 1, e);
        q0.push_back(e);
        model_frame(1, cust, key, inv, cyc + 1, e);
        q1.push_back(e);
        for (int i = 0; i < gap; i++) send_bit(1'b1);
    endtask

    // Stimulus
    initial begin
        logic [7:0]  key, inv;
        logic [15:0] cust;
        reset  = 1'b1;
        serial = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (3) send_bit(1'b1);

        send_frame(16'h0000, 8'h05, 8'hFA, 1, 6);
        send_frame(16'h0000, 8'h05, 8'hFA, 2, 6);
        send_frame(16'h0000, 8'h05, 8'hFA, 3, 6);
        send_frame(16'h0000, 8'h06, 8'hF9, 1, 6);
        send_frame(16'h0000, 8'h05, 8'hFB, 1, 6);
        send_frame(16'h0000, 8'h05, 8'hFA, 1, 6);
        send_frame(16'h0000, 8'h25, 8'hDA, 1, 6);
        send_frame(16'h1234, 8'h03, 8'hFC, 1, 6);

        // abort mid key field with a one-cycle reset
        send_bit(1'b0);
        send_bit(1'b1);
        for (int i = 0; i < 16; i++) send_bit(1'b0);
        for (int i = 0; i < 3; i++) send_bit(1'b0);
        reset  = 1'b1;
        serial = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        repeat (3) send_bit(1'b1);
        send_frame(16'h0000, 8'h07, 8'hF8, 1, 6);

        // randomized frames
        key = 8'h00;
        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 2) != 0) key = 8'($urandom_range(0, 40));
            inv  = ($urandom_range(0, 3) == 0) ? 8'($urandom) : ~key;
            cust = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'h0000;
            send_frame(cust, key, inv, $urandom_range(1, 4), $urandom_range(4, 8));
        end

        // held key long enough to saturate the repeat counter
        for (int n = 0; n < 258; n++) send_frame(16'h0000, 8'h09, 8'hF6, 1, 4);

        repeat (10) send_bit(1'b1);
        done = 1;
    end

    bit prev_r[2];
    bit prev_e[2];
    int run_len[2];
    int err_len[2];

    task automatic pop_exp(input int idx, output exp_t e, output bit ok);
        ok = 1;
        if (idx == 0 && q0.size() > 0) e = q0.pop_front();
        else if (idx == 1 && q1.size() > 0) e = q1.pop_front();
        else begin
            ok = 0;
            e.is_err = 0; e.key = 8'hFF; e.cc = 16'h0; e.rep = 8'h0; e.cyc = 0;
            check("unexpected_output", idx, 1, 0);
        end
    endtask

    task automatic mon(input int idx, input logic rdy, input logic [7:0] key, input logic [15:0] cc,
                       input logic err, input logic [7:0] rep);
        exp_t e;
        bit   ok;
        if (rst_q === 1'b1) begin
            check("rst_ready", idx, 32'(rdy), 0);
            check("rst_key", idx, 32'(key), 32'hFF);
            check("rst_custom", idx, 32'(cc), 0);
            check("rst_error", idx, 32'(err), 0);
            check("rst_repeat", idx, 32'(rep), 0);
            prev_r[idx] = 0; prev_e[idx] = 0; run_len[idx] = 0; err_len[idx] = 0;
            return;
        end
        if (rst_q !== 1'b0) return;
        if (!rdy) check("idle_key", idx, 32'(key), 32'hFF);
        if (rdy && !prev_r[idx]) begin
            pop_exp(idx, e, ok);
            if (ok) begin
                check("kind_accept", idx, 32'(e.is_err), 0);
                check("key", idx, 32'(key), 32'(e.key));
                check("custom", idx, 32'(cc), 32'(e.cc));
                check("repeat", idx, 32'(rep), 32'(e.rep));
                check("ready_cycle", idx, 32'(cyc), 32'(e.cyc));
            end
            run_len[idx] = 1;
        end else if (rdy) begin
            run_len[idx]++;
        end else if (prev_r[idx]) begin
            check("ready_len", idx, 32'(run_len[idx]), 3);
        end
        if (err && !prev_e[idx]) begin
            pop_exp(idx, e, ok);
            if (ok) begin
                check("kind_error", idx, 32'(e.is_err), 1);
                check("err_ready", idx, 32'(rdy), 0);
                check("err_custom", idx, 32'(cc), 32'(e.cc));
                check("err_repeat", idx, 32'(rep), 0);
                check("err_cycle", idx, 32'(cyc), 32'(e.cyc));
            end
            err_len[idx] = 1;
        end else if (err) begin
            err_len[idx]++;
        end else if (prev_e[idx]) begin
            check("err_len", idx, 32'(err_len[idx]), 1);
        end
        prev_r[idx] = rdy;
        prev_e[idx] = err;
    endtask

    // Monitor / scoreboard
    initial begin
        int guard;
        guard = 0;
        while (!done && guard < 60000) begin
            @(negedge clk);
            #1;
            mon(0, r0, k0, c0, e0, p0);
            mon(1, r1, k1, c1, e1, p1);
            guard++;
        end
        if (!done) check("timeout", 0, 1, 0);
        check("leftover_q", 0, 32'(q0.size()), 0);
        check("leftover_q", 1, 32'(q1.size()), 0);
        check("final_ready", 0, 32'(r0), 0);
        check("final_ready", 1, 32'(r1), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/remote_controller_param.md
Name: remote_controller_param

Overview:
Parametrised successor to the single-format IR remote decoder. Deserialises one bit per clock from a serial line into a frame: start sequence, custom (address) code, key code, inverted key code. Validates the frame, reports key, custom code, a repeat count for held keys, and an error pulse for rejected frames. Sits between the serial front-end and the key-handling logic.

Parameters:
CUSTOM_BITS, 16, width of custom code field (2..32)
KEY_BITS, 8, width of key and inverted-key fields (2..16)
CHECK_CUSTOM, 1, 1 = reject frames whose custom code differs from CUSTOM_ID; 0 = accept any custom code
CUSTOM_ID, 0, expected custom code, CUSTOM_BITS wide
MAX_KEY, 31, highest legal key code; larger codes are rejected
READY_CYCLES, 3, number of cycles ready is held high per valid frame (>=1)

Ports:
clk  input  1  system clock; all logic on rising edge
reset  input  1  synchronous, active-high reset
serial  input  1  serial data, one bit sampled per clk, MSB first per field
ready  output  1  high for READY_CYCLES cycles per accepted frame
remote_key  output  KEY_BITS  decoded key while ready=1, else all ones
custom_code  output  CUSTOM_BITS  custom code of last accepted frame
frame_error  output  1  one-cycle pulse per rejected frame
repeat_count  output  8  consecutive identical accepted keys minus one, saturating at 255

Behaviour:
- All outputs registered. Reset (reset=1 at a rising edge): state IDLE, ready=0, remote_key=all ones, custom_code=0, frame_error=0, repeat_count=0, shift registers/counters=0, last-key-valid flag=0. Reset overrides any state, including mid-frame.
- States: IDLE, WAIT_HIGH, CUSTOM, KEY, INV, CHECK, VALID.
- IDLE: serial=0 -> WAIT_HIGH; else stay. Shift registers and bit counter cleared.
- WAIT_HIGH: serial=1 -> CUSTOM; else stay (low phase may last any length).
- CUSTOM: shift serial into custom register each cycle; after CUSTOM_BITS samples -> KEY, counter cleared.
- KEY: shift KEY_BITS samples into key register -> INV.
- INV: shift KEY_BITS samples into inverted-key register -> CHECK.
- CHECK (one cycle, serial ignored): frame accepted iff (key XOR inv) == all ones AND key <= MAX_KEY (unsigned) AND (CHECK_CUSTOM=0 OR custom == CUSTOM_ID).
  - Accepted -> VALID; at the same edge ready<=1, remote_key<=key, custom_code<=custom; repeat_count<=(last-key-valid AND key==last_key) ? sat(repeat_count+1) : 0; last_key<=key; last-key-valid<=1.
  - Rejected -> IDLE; frame_error<=1 for exactly one cycle; repeat_count<=0; last-key-valid<=0; ready, remote_key, custom_code unchanged.
- VALID: ready held 1 for exactly READY_CYCLES cycles, serial ignored; then -> IDLE with ready<=0, remote_key<=all ones at the same edge.
- Timing: first custom bit sampled at the edge after the one where WAIT_HIGH sees serial=1. Last INV bit at edge N; CHECK at N+1; ready/frame_error visible after edge N+1.
- Frame start low must not be recognised while in CUSTOM..VALID; detection resumes only in IDLE.
- repeat_count at 255 stays 255 on further identical keys.

Test Plan:
- Defaults; start 0,1; custom 0x0000; key 0x05; inv 0xFA -> ready high exactly 3 cycles starting 1 cycle after last inv bit, remote_key=0x05, custom_code=0x0000, repeat_count=0, frame_error=0.
- Same frame twice more, then key 0x06/0xF9 -> repeat_count 1, 2, then 0; remote_key 0x05, 0x05, 0x06.
- Key 0x05, inv 0xFB -> single-cycle frame_error, ready stays 0, remote_key=0xFF; next valid 0x05 frame gives repeat_count=0.
- Key 0x25, inv 0xDA (complement correct, >MAX_KEY) -> frame_error pulse, no ready.
- Custom 0x1234, key 0x03/0xFC: CHECK_CUSTOM=1 -> frame_error; CHECK_CUSTOM=0 -> accepted, custom_code=0x1234.
- Assert reset for 1 cycle mid KEY field -> all outputs at reset values next cycle; following full valid frame 0x07/0xF8 decodes with repeat_count=0.
